// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, oversample
//                ratio and the baud-divider computation used by rx and tx.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Number of ticks per serial bit period
    localparam int OVERSAMPLE = 16;

    // Receiver FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_start  = 3'd1;
    localparam state_t c_st_data   = 3'd2;
    localparam state_t c_st_parity = 3'd3;
    localparam state_t c_st_stop   = 3'd4;

    // Clocks per oversample tick; never below one so the tick generator
    // always has a legal period even for very high baud rates.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Free-running divider producing a one-clock tick every DIV
//                clocks. clr holds the divider at zero so the first tick
//                after release is phase-aligned to the start of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Divider counter, wraps after DIV clocks, held at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x oversampling UART receiver, 8 data bits LSB first,
//                one stop bit. Mid-bit sampling of a synchronised line,
//                start-glitch rejection and framing-error detection.
//                Optional even-parity bit when UART_RX_PARITY_EN is defined
//                (adds the PARITY state and the parity_err output).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int         c_div      = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] c_os_mid   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] c_os_last  = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t     c_st_after_data = c_st_parity;
`else
    localparam state_t     c_st_after_data = c_st_stop;
`endif

    logic       r_sync1;
    logic       r_sync2;
    logic       r_rx_prev;
    logic       w_rx_s;
    logic       w_tick;
    logic       w_clr;
    state_t     r_state;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_stop_hold;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bit;
    logic       w_par_ok;
`endif

    assign w_rx_s = r_sync2;
    // Divider runs only while a frame is in progress
    assign w_clr  = (r_state == c_st_idle);
    assign busy   = (r_state != c_st_idle);
`ifdef UART_RX_PARITY_EN
    assign w_par_ok = ((^r_shift) ^ r_par_bit) == 1'b0;
`endif

    // Two-flop synchroniser plus previous-value flop for falling-edge detect;
    // both reset high so a line held low through reset is not a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    baud_tick_gen #(
        .DIV (c_div)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Frame FSM: start qualification, data shift, stop check, output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_os_cnt    <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_stop_hold <= 1'b0;
            dout        <= 8'h00;
            dout_rdy    <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            dout_rdy  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    r_os_cnt    <= 4'd0;
                    r_bit_cnt   <= 3'd0;
                    r_stop_hold <= 1'b0;
                    if (!w_rx_s && r_rx_prev) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_os_mid) begin
                            // Still low at mid start bit: real start, else glitch
                            r_os_cnt <= 4'd0;
                            r_state  <= w_rx_s ? c_st_idle : c_st_data;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (r_os_cnt == c_os_last) begin
                            r_shift   <= {w_rx_s, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= c_st_after_data;
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_st_parity: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (r_os_cnt == c_os_last) begin
                            r_par_bit <= w_rx_s;
                            r_state   <= c_st_stop;
                        end
                    end
                end
`endif
                c_st_stop: begin
                    if (r_stop_hold) begin
                        // Broken frame: wait for the line to return idle
                        if (w_rx_s) begin
                            r_state <= c_st_idle;
                        end
                    end else if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (r_os_cnt == c_os_last) begin
                            if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                                if (w_par_ok) begin
                                    dout     <= r_shift;
                                    dout_rdy <= 1'b1;
                                end else begin
                                    parity_err <= 1'b1;
                                end
`else
                                dout     <= r_shift;
                                dout_rdy <= 1'b1;
`endif
                                r_state <= c_st_idle;
                            end else begin
                                frame_err   <= 1'b1;
                                r_stop_hold <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are driven as bit
//                sequences on rx; a frame-level model predicts the number of
//                dout_rdy / frame_err (/ parity_err) pulses and the held dout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN     = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PAR_EN     = 1'b0;
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       dout_rdy;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (dout),
        .dout_rdy   (dout_rdy),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int   rdy_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap = 0, long_pulse = 0;
    int   rdy_last = -1, rdy_prev = -1;
    logic prev_rdy = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
    always @(negedge clk) begin
        if (dout_rdy === 1'b1) begin
            rdy_cnt  <= rdy_cnt + 1;
            rdy_prev <= rdy_last;
            rdy_last <= cyc;
        end
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if ((dout_rdy && frame_err) || (dout_rdy && parity_err) || (frame_err && parity_err))
            overlap <= overlap + 1;
        if ((dout_rdy && prev_rdy) || (frame_err && prev_ferr) || (parity_err && prev_perr))
            long_pulse <= long_pulse + 1;
        prev_rdy  <= dout_rdy;
        prev_ferr <= frame_err;
        prev_perr <= parity_err;
    end

    // Reference model state
    int         exp_rdy = 0, exp_ferr = 0, exp_perr = 0;
    logic [7:0] exp_dout = 8'h00;
    int         frame_start = 0;
    int         total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Drive one whole frame and record its expected outcome
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (PAR_EN) send_bit(par_ok ? (^b) : ~(^b));
        send_bit(stop_ok);
        if (!stop_ok)              exp_ferr++;
        else if (PAR_EN && !par_ok) exp_perr++;
        else begin
            exp_rdy++;
            exp_dout = b;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rdy_cnt"},  rdy_cnt,  exp_rdy);
        check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "_perr_cnt"}, perr_cnt, exp_perr);
        check({tag, "_dout"},     {24'd0, dout}, {24'd0, exp_dout});
        check({tag, "_overlap"},  overlap, 0);
        check({tag, "_long"},     long_pulse, 0);
    endtask

    // dout_rdy must land just after mid-stop-bit (plus synchroniser delay)
    task automatic check_latency(input string tag);
        int d;
        d = rdy_last - frame_start;
        check({tag, "_latency_in_stop"},
              (d >= FRAME_CLKS - 10 && d < FRAME_CLKS) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #(500000 * 10);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         s_ok;
        bit         p_ok;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dout",      {24'd0, dout},      32'h00);
        check("reset_dout_rdy",  {31'd0, dout_rdy},  32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean 0x55
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_model("f55");
        check_latency("f55");

        // Short low glitch: busy pulses, no output
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check_model("glitch");

        // 0xA3 with low stop bit: framing error, dout keeps 0x55
        send_frame(8'hA3, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("ferr_hold_busy", {31'd0, busy}, 32'd1);
        check_model("fA3");
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_release_busy", {31'd0, busy}, 32'd0);

        // Back-to-back 0x00 then 0xFF without idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_model("b2b");
        check("b2b_spacing", rdy_last - rdy_prev, FRAME_CLKS);

        // Reset during data bit 4 of 0x3C
        b = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rx = b[4];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_dout = 8'h00;
        check("midrst_dout",      {24'd0, dout},      32'h00);
        check("midrst_dout_rdy",  {31'd0, dout_rdy},  32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_model("f81");
        check_latency("f81");

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_model("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_model("par_good");
`endif

        // Randomised frames with random gaps and occasional errors
        for (int n = 0; n < 14; n++) begin
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            p_ok = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
            send_frame(b, s_ok, p_ok);
            if (s_ok && p_ok) check_latency("rnd");
            check_model("rnd");
            if (!s_ok) begin
                repeat ($urandom_range(0, 9)) @(negedge clk);
                rx = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 7)) @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_model("final");
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
